// File: rtl/char_sched_pkg.sv
// Shared types and constants for the character scheduler: FSM states,
// the queued character event record and default pacing values.
package char_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } sched_state_e;

    typedef struct packed {
        logic       bk;
        logic [7:0] ascii;
    } char_ev_t;

    localparam logic [7:0] RESET_CHAR        = 8'h20;
    localparam int         DEF_GAP_CYCLES    = 2500;
    localparam int         DEF_BK_GAP_CYCLES = 7500;

endpackage

// File: rtl/char_fifo.sv
// Small synchronous FIFO holding {bk, ascii} character events for one requester.
// A push while full is only accepted when a pop happens in the same cycle.
module char_fifo
    import char_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  char_ev_t din,
    output char_ev_t dout,
    output logic     empty,
    output logic     full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    char_ev_t      mem_q [DEPTH];

    logic do_pop;
    logic do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/char_sched.sv
// Round-robin scheduler that paces character events from two requesters onto
// the shared ds/back_sp/ascii bus; sinks have no ready, so spacing is timed.
module char_sched
    import char_sched_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int BK_GAP_CYCLES = DEF_BK_GAP_CYCLES,
    parameter int CW            = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_ds,
    input  logic       req0_bk,
    input  logic [7:0] req0_ascii,
    input  logic       req1_ds,
    input  logic       req1_bk,
    input  logic [7:0] req1_ascii,
    output logic       ds,
    output logic       back_sp,
    output logic [7:0] ascii_out,
    output logic       grant_id,
    output logic       busy,
    output logic       drop0,
    output logic       drop1
);

    localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BK_GAP_LOAD = CW'(BK_GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    sched_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic          ds_q;
    logic          back_sp_q;
    logic [7:0]    ascii_q;
    logic          grant_q;
    logic          prio_q;
    logic          drop0_q;
    logic          drop1_q;

    char_ev_t din0, din1, dout0, dout1, grant_ev;
    logic     empty0, empty1, full0, full1;
    logic     pop0, pop1;
    logic     grant_valid, grant_sel;

    assign din0 = '{bk: req0_bk, ascii: req0_ascii};
    assign din1 = '{bk: req1_bk, ascii: req1_ascii};

    char_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (req0_ds),
        .pop   (pop0),
        .din   (din0),
        .dout  (dout0),
        .empty (empty0),
        .full  (full0)
    );

    char_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (req1_ds),
        .pop   (pop1),
        .din   (din1),
        .dout  (dout1),
        .empty (empty1),
        .full  (full1)
    );

    // prio_q only matters when both FIFOs hold work; otherwise serve whoever has it.
    always_comb begin
        grant_valid = (state_q == IDLE) && (!empty0 || !empty1);
        if (!empty0 && !empty1) grant_sel = prio_q;
        else                    grant_sel = empty0;
        pop0     = grant_valid && !grant_sel;
        pop1     = grant_valid && grant_sel;
        grant_ev = grant_sel ? dout1 : dout0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ds_q      <= 1'b0;
            back_sp_q <= 1'b0;
            ascii_q   <= RESET_CHAR;
            grant_q   <= 1'b0;
            prio_q    <= 1'b0;
            drop0_q   <= 1'b0;
            drop1_q   <= 1'b0;
        end else begin
            drop0_q <= req0_ds && full0 && !pop0;
            drop1_q <= req1_ds && full1 && !pop1;
            ds_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        back_sp_q <= grant_ev.bk;
                        ascii_q   <= grant_ev.ascii;
                        grant_q   <= grant_sel;
                        prio_q    <= ~grant_sel;
                        ds_q      <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= back_sp_q ? BK_GAP_LOAD : GAP_LOAD;
                    state_q <= GAP;
                end
                GAP: begin
                    if (cnt_q == '0) state_q <= IDLE;
                    else             cnt_q   <= cnt_q - CNT_ONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ds        = ds_q;
    assign back_sp   = back_sp_q;
    assign ascii_out = ascii_q;
    assign grant_id  = grant_q;
    assign drop0     = drop0_q;
    assign drop1     = drop1_q;
    assign busy      = (state_q != IDLE) || !empty0 || !empty1;

endmodule

// File: tb/tb_char_sched.sv
// Directed self-checking bench for char_sched with short pacing gaps
// (GAP_CYCLES=4, BK_GAP_CYCLES=8, DEPTH=4); ds events are logged by cycle.
module tb_char_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_ds, req0_bk, req1_ds, req1_bk;
    logic [7:0] req0_ascii, req1_ascii;
    logic       ds, back_sp, grant_id, busy, drop0, drop1;
    logic [7:0] ascii_out;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int         dsCyc[$];
    logic [7:0] dsAscii[$];
    logic       dsBk[$];
    logic       dsGrant[$];
    int         drop0Cyc[$];
    int         drop1Cyc[$];

    char_sched #(
        .DEPTH        (4),
        .GAP_CYCLES   (4),
        .BK_GAP_CYCLES(8),
        .CW           (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_ds    (req0_ds),
        .req0_bk    (req0_bk),
        .req0_ascii (req0_ascii),
        .req1_ds    (req1_ds),
        .req1_bk    (req1_bk),
        .req1_ascii (req1_ascii),
        .ds         (ds),
        .back_sp    (back_sp),
        .ascii_out  (ascii_out),
        .grant_id   (grant_id),
        .busy       (busy),
        .drop0      (drop0),
        .drop1      (drop1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every bus strobe and drop pulse with the cycle it appeared in.
    always @(negedge clk) begin
        if (ds === 1'b1) begin
            dsCyc.push_back(cyc);
            dsAscii.push_back(ascii_out);
            dsBk.push_back(back_sp);
            dsGrant.push_back(grant_id);
        end
        if (drop0 === 1'b1) drop0Cyc.push_back(cyc);
        if (drop1 === 1'b1) drop1Cyc.push_back(cyc);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic d0, input logic b0, input logic [7:0] a0,
                                 input logic d1, input logic b1, input logic [7:0] a1);
        req0_ds = d0; req0_bk = b0; req0_ascii = a0;
        req1_ds = d1; req1_bk = b1; req1_ascii = a1;
        @(negedge clk);
        req0_ds = 1'b0; req0_bk = 1'b0;
        req1_ds = 1'b0; req1_bk = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int maxCyc);
        int n = 0;
        while (busy !== 1'b0 && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic clearLogs();
        dsCyc.delete(); dsAscii.delete(); dsBk.delete(); dsGrant.delete();
        drop0Cyc.delete(); drop1Cyc.delete();
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ds"},      {31'd0, ds},       32'd0);
        checkOutput({tag, "_back_sp"}, {31'd0, back_sp},  32'd0);
        checkOutput({tag, "_ascii"},   {24'd0, ascii_out}, 32'h20);
        checkOutput({tag, "_grant"},   {31'd0, grant_id}, 32'd0);
        checkOutput({tag, "_busy"},    {31'd0, busy},     32'd0);
        checkOutput({tag, "_drop0"},   {31'd0, drop0},    32'd0);
        checkOutput({tag, "_drop1"},   {31'd0, drop1},    32'd0);
    endtask

    initial begin
        int s;
        int busyHigh;
        logic [7:0] expAscii5 [8];
        logic       expGrant5 [8];

        reset = 1'b1;
        req0_ds = 1'b0; req0_bk = 1'b0; req0_ascii = 8'h00;
        req1_ds = 1'b0; req1_bk = 1'b0; req1_ascii = 8'h00;
        doReset();
        checkResetOutputs("reset");
        repeat (3) @(negedge clk);

        // Single character: latency, payload and busy release.
        clearLogs();
        s = cyc;
        applyStimulus(1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 8'h00);
        busyHigh = 0;
        for (int k = 1; k <= 6; k++) begin
            if (busy === 1'b1) busyHigh++;
            @(negedge clk);
        end
        checkOutput("t1_busy_high_cycles", busyHigh, 6);
        checkOutput("t1_busy_low", {31'd0, busy}, 32'd0);
        checkOutput("t1_ds_count", dsCyc.size(), 1);
        if (dsCyc.size() > 0) begin
            checkOutput("t1_latency", dsCyc[0] - s, 2);
            checkOutput("t1_ascii",   {24'd0, dsAscii[0]}, 32'h41);
            checkOutput("t1_bk",      {31'd0, dsBk[0]},    32'd0);
            checkOutput("t1_grant",   {31'd0, dsGrant[0]}, 32'd0);
        end
        checkOutput("t1_hold_ascii", {24'd0, ascii_out}, 32'h41);

        // Simultaneous requests right after reset.
        doReset();
        clearLogs();
        s = cyc;
        applyStimulus(1'b1, 1'b0, 8'h48, 1'b1, 1'b0, 8'h69);
        waitIdle("t2_idle_timeout", 100);
        checkOutput("t2_ds_count", dsCyc.size(), 2);
        if (dsCyc.size() > 1) begin
            checkOutput("t2_latency", dsCyc[0] - s, 2);
            checkOutput("t2_ascii0",  {24'd0, dsAscii[0]}, 32'h48);
            checkOutput("t2_grant0",  {31'd0, dsGrant[0]}, 32'd0);
            checkOutput("t2_ascii1",  {24'd0, dsAscii[1]}, 32'h69);
            checkOutput("t2_grant1",  {31'd0, dsGrant[1]}, 32'd1);
            checkOutput("t2_spacing", dsCyc[1] - dsCyc[0], 6);
        end
        checkOutput("t2_drops", drop0Cyc.size() + drop1Cyc.size(), 0);

        // Backspace stretches the following gap.
        clearLogs();
        s = cyc;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h78);
        waitIdle("t3_idle_timeout", 100);
        checkOutput("t3_ds_count", dsCyc.size(), 2);
        if (dsCyc.size() > 1) begin
            checkOutput("t3_bk0",     {31'd0, dsBk[0]},    32'd1);
            checkOutput("t3_ascii0",  {24'd0, dsAscii[0]}, 32'h08);
            checkOutput("t3_grant0",  {31'd0, dsGrant[0]}, 32'd1);
            checkOutput("t3_ascii1",  {24'd0, dsAscii[1]}, 32'h78);
            checkOutput("t3_bk1",     {31'd0, dsBk[1]},    32'd0);
            checkOutput("t3_spacing", dsCyc[1] - dsCyc[0], 10);
        end

        // Overflow: six back-to-back pushes into a depth-4 FIFO.
        clearLogs();
        s = cyc;
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, 1'b0, 8'h61 + 8'(k), 1'b0, 1'b0, 8'h00);
        waitIdle("t4_idle_timeout", 200);
        checkOutput("t4_ds_count", dsCyc.size(), 5);
        for (int k = 0; k < 5 && k < dsCyc.size(); k++) begin
            checkOutput($sformatf("t4_ascii%0d", k), {24'd0, dsAscii[k]}, 32'h61 + k);
            if (k > 0) checkOutput($sformatf("t4_spacing%0d", k), dsCyc[k] - dsCyc[k-1], 6);
        end
        checkOutput("t4_drop0_count", drop0Cyc.size(), 1);
        if (drop0Cyc.size() > 0) checkOutput("t4_drop0_cycle", drop0Cyc[0] - s, 6);
        checkOutput("t4_drop1_count", drop1Cyc.size(), 0);

        // Both requesters saturated: strict alternation starting at 0.
        doReset();
        clearLogs();
        expAscii5 = '{8'h30, 8'h50, 8'h31, 8'h51, 8'h32, 8'h52, 8'h33, 8'h53};
        expGrant5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b0, 8'h30 + 8'(k), 1'b1, 1'b0, 8'h50 + 8'(k));
        waitIdle("t5_idle_timeout", 500);
        checkOutput("t5_ds_count", dsCyc.size(), 8);
        for (int k = 0; k < 8 && k < dsCyc.size(); k++) begin
            checkOutput($sformatf("t5_grant%0d", k), {31'd0, dsGrant[k]}, {31'd0, expGrant5[k]});
            checkOutput($sformatf("t5_ascii%0d", k), {24'd0, dsAscii[k]}, {24'd0, expAscii5[k]});
        end
        checkOutput("t5_drops", drop0Cyc.size() + drop1Cyc.size(), 0);

        // Reset mid-gap with three entries still queued.
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b0, 8'h71 + 8'(k), 1'b0, 1'b0, 8'h00);
        checkOutput("t6_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clearLogs();
        checkResetOutputs("t6");
        repeat (20) @(negedge clk);
        checkOutput("t6_no_ds", dsCyc.size(), 0);
        checkOutput("t6_busy_after", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
